uart_tx: RTL and testbench
==========================

// Module: uart_tx
//
// PURPOSE
//   Serial UART transmitter. It pairs with uart_rx and shares the same 16x oversample tick (s_tick).
//   It loads a DBIT-wide word on a tx_start pulse and drives a frame on tx:
//   start bit (0), data LSB first, optional parity bit, then stop bit(s) (1).
//   It sits between the system-side byte source and the external TX pin.
//   The baud tick comes from the shared tick generator (50 MHz clk, one tick per 164 clocks, ~19200 baud).
//
// PARAMETERS
//   DBIT        8    data bits per frame (5..9)
//   SB_TICK     16   s_ticks of stop time: 16 = 1 stop bit, 24 = 1.5, 32 = 2
//   PARITY_EN   0    1 = insert a parity bit after the data
//   PARITY_ODD  0    0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)
//
// PORTS
//   clk           in   1     system clock; all logic on posedge
//   reset         in   1     synchronous, active-high reset
//   tx_start      in   1     1-clk request to send din; sampled only in IDLE
//   s_tick        in   1     1-clk enable pulse at 16x baud rate
//   din           in   DBIT  word to send; captured on the accepted tx_start
//   tx_busy       out  1     1 whenever state != IDLE
//   tx_done_tick  out  1     1-clk pulse at the end of the stop time
//   tx            out  1     serial line, registered, idles high
//
// BEHAVIOUR
//   Reset values (at the clock edge with reset = 1):
//     state = IDLE, s_reg = 0, n_reg = 0, b_reg = 0
//     tx = 1, tx_busy = 0, tx_done_tick = 0
//   Reset mid-frame aborts the frame: tx = 1 on the next edge, and no tx_done_tick is produced.
//   Registers:
//     s_reg  4-bit tick counter (5-bit when SB_TICK > 16)
//     n_reg  bit index, $clog2(DBIT) bits
//     b_reg  DBIT-bit shift register
//     p_reg  running parity (XOR of sent data bits)
//   FSM:
//     IDLE: tx = 1. If tx_start, then b_reg <= din, s_reg <= 0, p_reg <= PARITY_ODD,
//       and go to START. tx falls on the same edge that accepts tx_start (latency 1 clk).
//     START: tx = 0. On each s_tick: if s_reg == 15, then s_reg <= 0, n_reg <= 0 and go to DATA;
//       else s_reg++.
//     DATA: tx = b_reg[0]. On s_tick with s_reg == 15:
//       b_reg >>= 1, p_reg ^= b_reg[0], s_reg <= 0.
//       If n_reg == DBIT-1, go to PARITY (PARITY_EN = 1) or to STOP; else n_reg++.
//     PARITY: tx = p_reg, held for 16 s_ticks, then go to STOP.
//     STOP: tx = 1. On s_tick with s_reg == SB_TICK-1: tx_done_tick = 1 for that clock
//       and go to IDLE.
//   Each bit lasts exactly 16 s_ticks. Clocks without s_tick hold all counters.
//   A tx_start outside IDLE is ignored (not queued). This includes the cycle that raises tx_done_tick.
//   The earliest back-to-back start is the clock after tx_done_tick.
//   din is don't-care except on the accepted tx_start clock.
//   An s_tick coinciding with an accepted tx_start is not counted toward START.
//   tx is driven from a register (tx_reg); it has no combinational path from inputs.
//
// STRUCTURE
//   Shared package uart_pkg:
//     FSM state localparams (IDLE, START, DATA, PARITY, STOP), OVERSAMPLE = 16
//     the same encoding that uart_rx uses
//   There are no sub-modules: a single FSM plus datapath.
//   s_tick comes from the external shared tick generator, not from inside this block.
//
// TESTING  (clk 20 ns, s_tick every 164 clks => bit = 2624 clks, 52480 ns)
//   1. Reset, idle: after reset, hold tx_start = 0 for 10 bit times -> tx = 1, tx_busy = 0, no tx_done_tick.
//   2. Basic frame: din = 8'hD1, tx_start pulse -> tx bits 0,1,0,0,0,1,0,1,1 then stop 1.
//      Each bit lasts 16 s_ticks. tx_done_tick is a single clk after 10 bit times.
//      Loopback into uart_rx gives dout = 8'hD1.
//   3. Parity: PARITY_EN = 1, din = 8'hD1 -> parity bit 0 (even) or 1 (PARITY_ODD = 1),
//      then tx_done_tick after 11 bit times.
//   4. Busy ignore: tx_start with din = 8'h55 mid-DATA of an 8'hA3 frame -> the frame stays 8'hA3
//      and no second frame follows.
//   5. Back-to-back: tx_start on the clk after tx_done_tick with din = 8'h0F -> START begins with no idle bit.
//      Loopback yields 8'hA3 then 8'h0F.
//   6. Reset mid-frame: assert reset during the data bit n = 4 -> tx = 1 next edge, tx_busy = 0, no tx_done_tick.
//      A following 8'h3C frame is correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// uart_tx and uart_rx both import this package and use the same encoding.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Stop time can exceed one bit (1.5 or 2 stop bits), which needs a wider tick counter.
    function automatic int unsigned tick_cnt_width(input int unsigned sb_tick);
        return (sb_tick > OVERSAMPLE) ? 5 : 4;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity, stop time.
// Bit timing comes from the shared 16x oversample tick s_tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_start,
    input  logic            s_tick,
    input  logic [DBIT-1:0] din,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    localparam int unsigned SW = tick_cnt_width(SB_TICK);
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic          P_INIT = (PARITY_ODD != 0);
    localparam logic          HAS_P  = (PARITY_EN != 0);

    uart_state_e     state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            p_q, p_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_d     = p_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    state_d = START;
                    b_d     = din;
                    s_d     = '0;
                    p_d     = P_INIT;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        b_d = b_q >> 1;
                        p_d = p_q ^ b_q[0];
                        s_d = '0;
                        if (n_q == N_LAST) begin
                            state_d = HAS_P ? PARITY : STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        s_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so tx changes on the same edge as the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            PARITY:  tx_d = p_d;
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Done marks the clock whose tick ends the stop time, so a start on that clock is still ignored.
    assign tx_done_tick = done_d & ~reset;
    assign tx_busy      = busy_q;
    assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one default instance plus even/odd parity instances.
// Frames are sampled at bit centres counted in s_ticks from the accepting edge.
module tb_uart_tx;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset, s_tick, start0, startp;
    logic [7:0] din0, dinp;
    logic       tx0, busy0, done0;
    logic       txe, busye, donee;
    logic       txo, busyo, doneo;

    int checks = 0;
    int errors = 0;
    int done0_n = 0, donee_n = 0, doneo_n = 0;

    always #10 clk = ~clk;

    uart_tx dut0 (
        .clk(clk), .reset(reset), .tx_start(start0), .s_tick(s_tick), .din(din0),
        .tx_busy(busy0), .tx_done_tick(done0), .tx(tx0)
    );

    uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) dut_e (
        .clk(clk), .reset(reset), .tx_start(startp), .s_tick(s_tick), .din(dinp),
        .tx_busy(busye), .tx_done_tick(donee), .tx(txe)
    );

    uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) dut_o (
        .clk(clk), .reset(reset), .tx_start(startp), .s_tick(s_tick), .din(dinp),
        .tx_busy(busyo), .tx_done_tick(doneo), .tx(txo)
    );

    // s_tick changes just after posedge, so at a negedge it shows what the next edge will see.
    initial begin
        int c;
        c = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            s_tick = (c == DIV - 1);
            c = (c == DIV - 1) ? 0 : c + 1;
        end
    end

    always @(negedge clk) begin
        if (done0 === 1'b1) done0_n++;
        if (donee === 1'b1) donee_n++;
        if (doneo === 1'b1) doneo_n++;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] din;
        logic [9:0] fr;
        logic       pe;
        logic       po;
        bit         align;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        startp = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int c;
        c = 0;
        while (c < n) begin
            @(posedge clk);
            if (s_tick) c++;
            @(negedge clk);
            start0 = 1'b0;
            startp = 1'b0;
        end
    endtask

    task automatic sync_tick(input logic want);
        int g;
        g = 0;
        while (s_tick !== want && g < 2 * DIV) begin
            step();
            g++;
        end
        if (s_tick !== want) begin
            checks++;
            errors++;
            $display("FAIL sync_tick actual=%0b expected=%0b", s_tick, want);
        end
    endtask

    task automatic idle_watch(input string name, input int cycles);
        int viol;
        viol = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) viol++;
        end
        chk(name, viol[15:0], 16'd0);
    endtask

    // Entered at the negedge where start is asserted; returns at dut0's done clock
    // (with_par = 0) or one clock after the parity instances' done clock.
    task automatic run_frame(input logic [9:0] fr, input logic pe, input logic po,
                             input bit with_par, input int inject_k);
        logic exp_e, exp_o;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        startp = 1'b0;
        chk("tx_fall_latency", {15'd0, tx0}, 16'd0);
        chk("busy_rise", {15'd0, busy0}, 16'd1);
        for (int k = 0; k < 10; k++) begin
            wait_ticks((k == 0) ? 8 : 16);
            chk($sformatf("bit%0d", k), {15'd0, tx0}, {15'd0, fr[k]});
            chk($sformatf("busy_bit%0d", k), {15'd0, busy0}, 16'd1);
            if (with_par) begin
                exp_e = (k == 9) ? pe : fr[k];
                exp_o = (k == 9) ? po : fr[k];
                chk($sformatf("even_bit%0d", k), {15'd0, txe}, {15'd0, exp_e});
                chk($sformatf("odd_bit%0d", k), {15'd0, txo}, {15'd0, exp_o});
            end
            if (k == inject_k) begin
                din0 = 8'h55;
                start0 = 1'b1;
            end
        end
        wait_ticks(7);
        sync_tick(1'b1);
        chk("done_pulse", {15'd0, done0}, 16'd1);
        chk("tx_at_done", {15'd0, tx0}, 16'd1);
        chk("busy_at_done", {15'd0, busy0}, 16'd1);
        if (!with_par) return;
        step();
        chk("done_one_clk", {15'd0, done0}, 16'd0);
        chk("busy_fall", {15'd0, busy0}, 16'd0);
        wait_ticks(8);
        chk("even_stop", {15'd0, txe}, 16'd1);
        chk("odd_stop", {15'd0, txo}, 16'd1);
        chk("par_not_done_early", {14'd0, donee, doneo}, 16'd0);
        wait_ticks(7);
        sync_tick(1'b1);
        chk("par_done_pulse", {14'd0, donee, doneo}, 16'd3);
        step();
        chk("par_idle", {12'd0, donee, doneo, busye, busyo}, 16'd0);
    endtask

    initial begin
        int n0, ne, no;

        vecs[0] = '{8'hD1, 10'h3A2, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{8'h00, 10'h200, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 10'h3FE, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'h80, 10'h300, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h55, 10'h2AA, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'h07, 10'h20E, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 10'h202, 1'b1, 1'b0, 1'b1};

        reset = 1'b1;
        start0 = 1'b0;
        startp = 1'b0;
        din0 = '0;
        dinp = '0;
        repeat (3) @(negedge clk);
        chk("reset_tx", {15'd0, tx0}, 16'd1);
        chk("reset_busy", {15'd0, busy0}, 16'd0);
        chk("reset_done", {15'd0, done0}, 16'd0);
        chk("reset_par_tx", {14'd0, txe, txo}, 16'd3);
        reset = 1'b0;

        idle_watch("idle_hold", 160 * DIV);
        chk("idle_no_done", done0_n[15:0], 16'd0);

        foreach (vecs[i]) begin
            sync_tick(vecs[i].align);
            din0 = vecs[i].din;
            dinp = vecs[i].din;
            start0 = 1'b1;
            startp = 1'b1;
            n0 = done0_n;
            ne = donee_n;
            no = doneo_n;
            run_frame(vecs[i].fr, vecs[i].pe, vecs[i].po, 1'b1, -1);
            chk($sformatf("vec%0d_done_cnt", i), 16'(done0_n - n0), 16'd1);
            chk($sformatf("vec%0d_par_done_cnt", i), 16'(donee_n - ne + doneo_n - no), 16'd2);
        end

        // A start during DATA is dropped, not queued.
        sync_tick(1'b0);
        din0 = 8'hA3;
        start0 = 1'b1;
        n0 = done0_n;
        run_frame(10'h346, 1'b0, 1'b0, 1'b0, 4);
        idle_watch("busy_ignore_no_second_frame", 32 * DIV);
        chk("busy_ignore_done_cnt", 16'(done0_n - n0), 16'd1);

        // Start on the done clock is dropped; start on the following clock begins the next frame.
        sync_tick(1'b1);
        din0 = 8'hA3;
        start0 = 1'b1;
        run_frame(10'h346, 1'b0, 1'b0, 1'b0, -1);
        din0 = 8'hF0;
        start0 = 1'b1;
        step();
        chk("b2b_idle_clk", {14'd0, tx0, busy0}, 16'd2);
        din0 = 8'h0F;
        start0 = 1'b1;
        run_frame(10'h21E, 1'b0, 1'b0, 1'b0, -1);
        step();
        chk("b2b_done_one_clk", {15'd0, done0}, 16'd0);

        // Reset during data bit n = 4 aborts the frame.
        sync_tick(1'b0);
        din0 = 8'hA3;
        start0 = 1'b1;
        step();
        chk("rst_frame_started", {15'd0, tx0}, 16'd0);
        wait_ticks(8 + 16 * 5);
        chk("rst_frame_busy", {15'd0, busy0}, 16'd1);
        n0 = done0_n;
        reset = 1'b1;
        step();
        chk("rst_mid_tx", {15'd0, tx0}, 16'd1);
        chk("rst_mid_busy", {15'd0, busy0}, 16'd0);
        chk("rst_mid_done", {15'd0, done0}, 16'd0);
        reset = 1'b0;
        idle_watch("rst_mid_idle", 32 * DIV);
        chk("rst_mid_no_done", 16'(done0_n - n0), 16'd0);
        din0 = 8'h3C;
        start0 = 1'b1;
        run_frame(10'h278, 1'b0, 1'b0, 1'b0, -1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
